// File: rtl/cte_stream.sv
// Streaming YUV<->RGB colour-space converter: beat-grouping FSM, one compute stage, output FIFO.
// Define CTE_STREAM_SAT_EN to add the sticky saturation flag (sat_flag / sat_clr).
//   state  | meaning
//   IDLE   | no group open; next beat starts a group in the mode sampled from op_mode
//   Y2R_U  | expecting U (first beat, entered from IDLE)
//   Y2R_Y0 | expecting Y0
//   Y2R_V  | expecting V; emits RGB for Y0
//   Y2R_Y1 | expecting Y1; emits RGB for Y1, closes group
//   R2Y_P0 | expecting pixel 0 (first beat, entered from IDLE); emits U, Y0
//   R2Y_P1 | expecting pixel 1; emits V, Y1, closes group
module cte_stream #(
    parameter int PIX_BW     = 8,
    parameter int FRAC_BW    = 3,
    parameter int COEF_FRAC  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PIX_BW-1:0]   yuv_in,
    input  logic [3*PIX_BW-1:0] rgb_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3*PIX_BW-1:0] rgb_out,
    output logic [PIX_BW-1:0]   yuv_out
`ifdef CTE_STREAM_SAT_EN
    ,
    output logic                sat_flag,
    input  logic                sat_clr
`endif
);
    localparam int EW = 3 * PIX_BW;
    localparam int IW = PIX_BW + FRAC_BW + 3;
    localparam int CW = PIX_BW + COEF_FRAC + 3;
    localparam int XW = (CW > IW) ? CW : IW;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic signed [IW-1:0] K_RV  = IW'((13 * (2 ** FRAC_BW) + 4) / 8);
    localparam logic signed [IW-1:0] K_GU  = IW'((2 ** FRAC_BW + 2) / 4);
    localparam logic signed [IW-1:0] K_GV  = IW'((3 * (2 ** FRAC_BW) + 2) / 4);
    localparam logic signed [IW-1:0] K_BU  = IW'(2 * (2 ** FRAC_BW));
    localparam logic signed [IW-1:0] RND_Y = IW'(2 ** (FRAC_BW - 1));

    localparam logic signed [CW-1:0] K_YR  = CW'(306 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_YG  = CW'(601 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_YB  = CW'(117 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_UR  = CW'(-173 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_UG  = CW'(-339 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_UB  = CW'(512 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_VR  = CW'(512 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_VG  = CW'(-429 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] K_VB  = CW'(-83 * (2 ** COEF_FRAC) / 1024);
    localparam logic signed [CW-1:0] RND_C = CW'(2 ** (COEF_FRAC - 1));

    localparam logic signed [XW-1:0] MAX_U = XW'(2 ** PIX_BW - 1);
    localparam logic signed [XW-1:0] MAX_S = XW'(2 ** (PIX_BW - 1) - 1);
    localparam logic signed [XW-1:0] MIN_S = XW'(-(2 ** (PIX_BW - 1)));

    typedef enum logic [2:0] {IDLE, Y2R_U, Y2R_Y0, Y2R_V, Y2R_Y1, R2Y_P0, R2Y_P1} state_t;

    state_t                   state_q, state_d, st_eff;
    logic signed [PIX_BW-1:0] u_q, u_d, v_q, v_d;
    logic [PIX_BW-1:0]        y0_q, y0_d;
    logic [1:0]               stg_cnt_q, stg_cnt_d;
    logic [EW-1:0]            stg0_q, stg0_d, stg1_q, stg1_d;
    logic [EW-1:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [AW:0]              cnt_q;
    logic [AW+1:0]            used;
    logic                     in_fire, out_fire;
    logic signed [IW-1:0]     y_s, u_s, v_s, r_raw, g_raw, b_raw;
    logic signed [CW-1:0]     cr, cg, cb, yy_raw, uu_raw, vv_raw;
    logic signed [XW-1:0]     r_w, g_w, b_w, yy_w, ch_w;
    logic [PIX_BW-1:0]        r_c, g_c, b_c, yy_c, ch_c;

    function automatic logic [PIX_BW-1:0] clamp_u(input logic signed [XW-1:0] x);
        if (x[XW-1]) return '0;
        if (x > MAX_U) return '1;
        return x[PIX_BW-1:0];
    endfunction

    function automatic logic [PIX_BW-1:0] clamp_s(input logic signed [XW-1:0] x);
        if (x < MIN_S) return MIN_S[PIX_BW-1:0];
        if (x > MAX_S) return MAX_S[PIX_BW-1:0];
        return x[PIX_BW-1:0];
    endfunction

    // Stage and FIFO together never hold more than FIFO_DEPTH entries, so the stage always drains.
    assign used      = {1'b0, cnt_q} + (AW+2)'(stg_cnt_q);
    assign in_ready  = !reset && (used <= (AW+2)'(FIFO_DEPTH - 2));
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (cnt_q != '0);
    assign out_fire  = out_valid && out_ready;
    assign rgb_out   = out_valid ? mem[rd_ptr_q] : '0;
    assign yuv_out   = rgb_out[PIX_BW-1:0];

    // The first beat of a group is processed in the entry state chosen by op_mode.
    assign st_eff = (state_q == IDLE) ? (op_mode ? R2Y_P0 : Y2R_U) : state_q;

    always_comb begin
        y_s    = (st_eff == Y2R_V) ? $signed(IW'(y0_q)) : $signed(IW'(yuv_in));
        u_s    = IW'(u_q);
        v_s    = (st_eff == Y2R_V) ? IW'($signed(yuv_in)) : IW'(v_q);
        r_raw  = (y_s <<< FRAC_BW) + K_RV * v_s + RND_Y;
        g_raw  = (y_s <<< FRAC_BW) - K_GU * u_s - K_GV * v_s + RND_Y;
        b_raw  = (y_s <<< FRAC_BW) + K_BU * u_s + RND_Y;
        r_w    = XW'(r_raw >>> FRAC_BW);
        g_w    = XW'(g_raw >>> FRAC_BW);
        b_w    = XW'(b_raw >>> FRAC_BW);
        cr     = $signed(CW'(rgb_in[3*PIX_BW-1 -: PIX_BW]));
        cg     = $signed(CW'(rgb_in[2*PIX_BW-1 -: PIX_BW]));
        cb     = $signed(CW'(rgb_in[PIX_BW-1:0]));
        yy_raw = K_YR * cr + K_YG * cg + K_YB * cb + RND_C;
        uu_raw = K_UR * cr + K_UG * cg + K_UB * cb + RND_C;
        vv_raw = K_VR * cr + K_VG * cg + K_VB * cb + RND_C;
        yy_w   = XW'(yy_raw >>> COEF_FRAC);
        ch_w   = XW'(((st_eff == R2Y_P1) ? vv_raw : uu_raw) >>> COEF_FRAC);
        r_c    = clamp_u(r_w);
        g_c    = clamp_u(g_w);
        b_c    = clamp_u(b_w);
        yy_c   = clamp_u(yy_w);
        ch_c   = clamp_s(ch_w);
    end

    always_comb begin
        state_d   = state_q;
        u_d       = u_q;
        v_d       = v_q;
        y0_d      = y0_q;
        stg_cnt_d = 2'd0;
        stg0_d    = stg0_q;
        stg1_d    = stg1_q;
        if (in_fire) begin
            case (st_eff)
                Y2R_U: begin
                    u_d     = $signed(yuv_in);
                    state_d = Y2R_Y0;
                end
                Y2R_Y0: begin
                    y0_d    = yuv_in;
                    state_d = Y2R_V;
                end
                Y2R_V: begin
                    v_d       = $signed(yuv_in);
                    stg0_d    = {r_c, g_c, b_c};
                    stg_cnt_d = 2'd1;
                    state_d   = Y2R_Y1;
                end
                Y2R_Y1: begin
                    stg0_d    = {r_c, g_c, b_c};
                    stg_cnt_d = 2'd1;
                    state_d   = IDLE;
                end
                R2Y_P0: begin
                    stg0_d    = EW'(ch_c);
                    stg1_d    = EW'(yy_c);
                    stg_cnt_d = 2'd2;
                    state_d   = R2Y_P1;
                end
                R2Y_P1: begin
                    stg0_d    = EW'(ch_c);
                    stg1_d    = EW'(yy_c);
                    stg_cnt_d = 2'd2;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            u_q       <= '0;
            v_q       <= '0;
            y0_q      <= '0;
            stg_cnt_q <= '0;
            stg0_q    <= '0;
            stg1_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            u_q       <= u_d;
            v_q       <= v_d;
            y0_q      <= y0_d;
            stg_cnt_q <= stg_cnt_d;
            stg0_q    <= stg0_d;
            stg1_q    <= stg1_d;
            wr_ptr_q  <= wr_ptr_q + AW'(stg_cnt_q);
            if (out_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q     <= cnt_q + (AW+1)'(stg_cnt_q) - (AW+1)'(out_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && stg_cnt_q != 2'd0) begin
            mem[wr_ptr_q] <= stg0_q;
            if (stg_cnt_q == 2'd2) mem[wr_ptr_q + AW'(1)] <= stg1_q;
        end
    end

`ifdef CTE_STREAM_SAT_EN
    logic sat_hit, sat_q;

    function automatic logic oor_u(input logic signed [XW-1:0] x);
        return x[XW-1] || (x > MAX_U);
    endfunction

    function automatic logic oor_s(input logic signed [XW-1:0] x);
        return (x < MIN_S) || (x > MAX_S);
    endfunction

    always_comb begin
        sat_hit = 1'b0;
        if (in_fire) begin
            case (st_eff)
                Y2R_V, Y2R_Y1:  sat_hit = oor_u(r_w) || oor_u(g_w) || oor_u(b_w);
                R2Y_P0, R2Y_P1: sat_hit = oor_u(yy_w) || oor_s(ch_w);
                default:        sat_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || sat_clr) sat_q <= 1'b0;
        else if (sat_hit)     sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`endif
endmodule

// File: tb/tb_cte_stream.sv
// Scoreboard bench for cte_stream: directed beats push expected FIFO entries, a monitor pops and compares.
module tb_cte_stream;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [7:0]  yuv_in = '0;
    logic [7:0]  yuv_out;
    logic [23:0] rgb_in = '0;
    logic [23:0] rgb_out;
`ifdef CTE_STREAM_SAT_EN
    logic        sat_flag;
    logic        sat_clr = 1'b0;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          acc_snap;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v;

    always #5 clk = ~clk;

    cte_stream #(.PIX_BW(8), .FRAC_BW(3), .COEF_FRAC(10), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_mode   (op_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .yuv_in    (yuv_in),
        .rgb_in    (rgb_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rgb_out   (rgb_out),
        .yuv_out   (yuv_out)
`ifdef CTE_STREAM_SAT_EN
        ,
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
`endif
    );

    // Inputs only change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cnt++;
        if (out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got rgb_out=%h, nothing expected", rgb_out);
            end else begin
                exp_v = exp_q.pop_front();
                if (rgb_out !== exp_v || yuv_out !== exp_v[7:0]) begin
                    n_fail++;
                    $display("FAIL out_data: got rgb_out=%h yuv_out=%h, expected %h / %h",
                             rgb_out, yuv_out, exp_v, exp_v[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic beat(input logic m, input logic [7:0] y, input logic [23:0] rgb);
        int   n = 0;
        logic acc = 1'b0;
        op_mode  = m;
        yuv_in   = y;
        rgb_in   = rgb;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic yuv_group(input logic [7:0] u, input logic [7:0] y0, input logic [7:0] v,
                             input logic [7:0] y1, input logic [23:0] e0, input logic [23:0] e1);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        beat(1'b0, u, '0);
        beat(1'b0, y0, '0);
        beat(1'b0, v, '0);
        beat(1'b0, y1, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected earlier end");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_rgb_out", rgb_out, 0);
        check("reset_yuv_out", yuv_out, 0);
`ifdef CTE_STREAM_SAT_EN
        check("reset_sat_flag", sat_flag, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        yuv_group(8'd0, 8'd100, 8'd0, 8'd200, 24'h646464, 24'hC8C8C8);
        wait_drain();
`ifdef CTE_STREAM_SAT_EN
        check("sat_flag_no_clamp", sat_flag, 0);
`endif

        yuv_group(8'd64, 8'd100, 8'd64, 8'd255, 24'hCC24E4, 24'hFFBFFF);
        wait_drain();
`ifdef CTE_STREAM_SAT_EN
        check("sat_flag_set", sat_flag, 1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("sat_flag_cleared", sat_flag, 0);
`endif

        // Negative chroma drives R and B below zero.
        yuv_group(8'h80, 8'd10, 8'h80, 8'd0, 24'h008A00, 24'h008000);
        // Fractional results exercise round-half-up and the low clamp on G.
        yuv_group(8'd1, 8'd0, 8'd1, 8'd3, 24'h020002, 24'h050205);
        wait_drain();

        // Latency from accept edge, plus white/black conversion.
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h0000FF);
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
        beat(1'b1, 8'd0, 24'hFFFFFF);
        @(negedge clk);
        check("latency_one_edge", out_valid, 0);
        @(negedge clk);
        check("latency_two_edges", out_valid, 1);
        @(posedge clk);
        #1;
        beat(1'b1, 8'd0, 24'h000000);
        wait_drain();

        // Back-pressure: two pixels fill the FIFO, a third waits.
        out_ready = 1'b0;
        exp_q.push_back(24'h0000D5);
        exp_q.push_back(24'h00004C);
        exp_q.push_back(24'h0000EB);
        exp_q.push_back(24'h00001D);
        beat(1'b1, 8'd0, 24'hFF0000);
        beat(1'b1, 8'd0, 24'h0000FF);
        acc_snap = acc_cnt;
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h0000FF);
        op_mode  = 1'b1;
        rgb_in   = 24'hFFFFFF;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_no_accept", acc_cnt - acc_snap, 0);
        check("full_head_stable", rgb_out, 24'h0000D5);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat(1'b1, 8'd0, 24'hFFFFFF);
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
        beat(1'b1, 8'd0, 24'h000000);
        wait_drain();

        // Reset after Y0 discards the partial group.
        beat(1'b0, 8'd0, '0);
        beat(1'b0, 8'd77, '0);
        pulse_reset();
        yuv_group(8'd0, 8'd50, 8'd0, 8'd60, 24'h323232, 24'h3C3C3C);
        wait_drain();

        // op_mode flips mid-group; the group still finishes as YUV->RGB.
        exp_q.push_back(24'h141414);
        exp_q.push_back(24'h1E1E1E);
        beat(1'b0, 8'd0, '0);
        beat(1'b0, 8'd20, '0);
        beat(1'b1, 8'd0, 24'h123456);
        beat(1'b1, 8'd30, 24'h123456);
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h0000FF);
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h000000);
        beat(1'b1, 8'd0, 24'hFFFFFF);
        beat(1'b1, 8'd0, 24'h000000);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
